vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  640x480@60 VGA raster timing generator plus output register stage; sits directly upstream of the
//  VGA DAC pins, downstream of the pixel/pattern logic inside vga_toplevel. Derives a 25 MHz pixel
//  enable from clk50MHz, produces hsync/vsync, pixel coordinates and active-video flag. Registers
//  upstream RGB with syncs so colour, blanking and sync reach the pins on the same edge.
// PARAMETERS
//  H_ACTIVE 640  visible pixels/line       | H_FP 16  | H_SYNC 96 | H_BP 48   (H_TOTAL = 800)
//  V_ACTIVE 480  visible lines/frame       | V_FP 10  | V_SYNC 2  | V_BP 33   (V_TOTAL = 525)
//  HS_POL   0    hsync active level (0 = active-low) | VS_POL 0  vsync active level
//  PIX_DIV  2    clk50MHz cycles per pixel (>=1)
// PORTS
//  clk50MHz     in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  rgb_in       in   24  {r,g,b} for pixel (x_o,y_o), valid same pixel period
//  x_o          out  10  current horizontal count (0..H_TOTAL-1)
//  y_o          out  10  current vertical count (0..V_TOTAL-1)
//  active_o     out  1   x_o<H_ACTIVE && y_o<V_ACTIVE (combinational from counters)
//  pix_tick_o   out  1   1-clk pixel enable, high every PIX_DIV-th clock
//  frame_start_o out 1   1-clk pulse on the tick where counters wrap to (0,0)
//  vga_hs, vga_vs out 1  registered syncs
//  vga_blank_n  out  1   registered active flag (1 = visible)
//  vga_r, vga_g, vga_b out 8 each  registered colour, 0 while blanked
// BEHAVIOUR
//  - Reset (async, rst_n=0): div=0, h=0, v=0, pix_tick_o=0, frame_start_o=0, vga_hs=~HS_POL,
//    vga_vs=~VS_POL, vga_blank_n=0, vga_r/g/b=0. Release takes effect on next clk edge.
//  - Divider: div counts 0..PIX_DIV-1, wraps; pix_tick = (div==PIX_DIV-1). PIX_DIV=1 -> tick always 1.
//  - Counters advance only on pix_tick: h==H_TOTAL-1 -> h=0 and v increments; v==V_TOTAL-1 with h
//    wrap -> v=0. No other wrap; counters never exceed TOTAL-1.
//  - frame_start_o = pix_tick && h==H_TOTAL-1 && v==V_TOTAL-1 (registered, coincides with wrap edge
//    +0 latency, i.e. high during the clock in which x_o,y_o first read 0,0).
//  - Output stage, loaded on pix_tick from pre-edge counters (1-pixel latency, all pins aligned):
//    vga_hs = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751), else ~HS_POL;
//    vga_vs = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), else ~VS_POL;
//    vga_blank_n = active; {vga_r,vga_g,vga_b} = active ? rgb_in : 24'h0. Held between ticks.
//  - Widths: counters $clog2(H_TOTAL)/$clog2(V_TOTAL), zero-extended to 10 bits on x_o/y_o.
//  - Reset mid-frame: immediate return to reset values; raster restarts at (0,0), no partial pulse.
//  - Simultaneous h and v wrap: single edge, both counters 0, frame_start_o asserted once.
// STRUCTURE
//  - vga_pkg: timing localparams (H_TOTAL, V_TOTAL, sync start/end), typedef struct packed
//    {logic [7:0] r,g,b;} rgb_t used for rgb_in and output register.
//  - Sub-module vga_pix_tick (divider, PIX_DIV param, rst_n) -> pix_tick; rest in one always_ff
//    for counters and one for output stage.
// TESTING
//  1 rst_n=0 mid-run at arbitrary count -> all outputs at reset values immediately; after release
//    x_o=0,y_o=0, first pix_tick_o 2 clks later (PIX_DIV=2).
//  2 Free-run one line -> vga_hs period 1600 clks, low exactly 192 clks, falls 1 tick after h=656.
//  3 Free-run one frame -> vga_vs low 2 lines (1600 clks... =3200 clks), frame_start_o period 840000
//    clks, exactly one pulse per frame.
//  4 rgb_in=24'hFFFFFF constant -> vga_r/g/b=FF for 640 pixels per visible line, 0 from x=640 on
//    and on lines 480..524; vga_blank_n matches.
//  5 rgb_in={x_o[7:0],y_o[7:0],8'hA5} -> every output pixel equals value of previous tick's (x,y).
//  6 PIX_DIV=1 build -> pix_tick_o constantly 1, hs period 800 clks, timing otherwise identical.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, RGB payload type and window helper.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic        HS_POL   = 1'b0;
    localparam logic        VS_POL   = 1'b0;
    localparam int unsigned PIX_DIV  = 2;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned CHAN_W   = 8;

    typedef struct packed {
        logic [CHAN_W-1:0] r;
        logic [CHAN_W-1:0] g;
        logic [CHAN_W-1:0] b;
    } rgb_t;

    // True when pos lies in the half-open window [lo, hi).
    function automatic logic in_span(input int unsigned pos,
                                     input int unsigned lo,
                                     input int unsigned hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate enable: one-clock pulse every PIX_DIV system clocks.
module vga_pix_tick #(
    parameter int unsigned PIX_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick_o
);

    localparam int unsigned   DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;

    // Divider next state: count up, wrap after the last phase.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_MAX) begin
            div_d = '0;
        end
    end

    // Divider and registered tick; PIX_DIV=1 keeps the tick high after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= (div_q == DIV_MAX);
        end
    end

    assign pix_tick_o = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with pin-aligned sync/blank/colour register stage.
module vga_timing_gen
    import vga_pkg::rgb_t, vga_pkg::in_span;
#(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP,
    parameter logic        HS_POL   = vga_pkg::HS_POL,
    parameter logic        VS_POL   = vga_pkg::VS_POL,
    parameter int unsigned PIX_DIV  = vga_pkg::PIX_DIV
) (
    input  logic                            clk50MHz,
    input  logic                            rst_n,
    input  rgb_t                            rgb_in,
    output logic [vga_pkg::COORD_W-1:0]     x_o,
    output logic [vga_pkg::COORD_W-1:0]     y_o,
    output logic                            active_o,
    output logic                            pix_tick_o,
    output logic                            frame_start_o,
    output logic                            vga_hs,
    output logic                            vga_vs,
    output logic                            vga_blank_n,
    output logic [vga_pkg::CHAN_W-1:0]      vga_r,
    output logic [vga_pkg::CHAN_W-1:0]      vga_g,
    output logic [vga_pkg::CHAN_W-1:0]      vga_b
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned CW       = vga_pkg::COORD_W;

    localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL - 1);

    logic          pix_tick;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          frame_start_q, frame_start_d;

    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_n_q, blank_n_d;
    rgb_t          rgb_q, rgb_d;

    logic          active;
    logic          hs_window;
    logic          vs_window;

    vga_pix_tick #(
        .PIX_DIV    (PIX_DIV)
    ) u_pix_tick (
        .clk        (clk50MHz),
        .rst_n      (rst_n),
        .pix_tick_o (pix_tick)
    );

    // Raster position decode from the current (pre-edge) counters.
    always_comb begin
        active    = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
        hs_window = in_span(32'(h_q), HS_START, HS_END);
        vs_window = in_span(32'(v_q), VS_START, VS_END);
    end

    // Counter next state: advance on tick, wrap line then frame; flag the frame wrap.
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        frame_start_d = 1'b0;
        if (pix_tick) begin
            if (h_q == H_MAX) begin
                h_d = '0;
                if (v_q == V_MAX) begin
                    v_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_d = v_q + VW'(1);
                end
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    // Counter and frame-start registers.
    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Output stage next state: capture this pixel's sync/blank/colour on the tick, else hold.
    always_comb begin
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        rgb_d     = rgb_q;
        if (pix_tick) begin
            hs_d      = hs_window ? HS_POL : ~HS_POL;
            vs_d      = vs_window ? VS_POL : ~VS_POL;
            blank_n_d = active;
            rgb_d     = active ? rgb_in : '0;
        end
    end

    // Pin register stage: sync, blank and colour leave on the same edge.
    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            rgb_q     <= rgb_d;
        end
    end

    assign x_o           = CW'(h_q);
    assign y_o           = CW'(v_q);
    assign active_o      = active;
    assign pix_tick_o    = pix_tick;
    assign frame_start_o = frame_start_q;
    assign vga_hs        = hs_q;
    assign vga_vs        = vs_q;
    assign vga_blank_n   = blank_n_q;
    assign vga_r         = rgb_q.r;
    assign vga_g         = rgb_q.g;
    assign vga_b         = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: pixel-index model checked every cycle plus measured sync/frame timing.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act;
        logic        tick;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        blank;
        logic [23:0] rgb;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Edges since reset release; the model is a pure function of this count.
    int n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    // dut_a: default 640x480, PIX_DIV=2, coordinate pattern colour
    logic [9:0] x_a, y_a; logic act_a, tick_a, fs_a, hs_a, vs_a, bl_a;
    logic [7:0] r_a, g_a, b_a; logic [23:0] rgb_a;
    assign rgb_a = {x_a[7:0], y_a[7:0], 8'hA5};
    vga_timing_gen u_dut_a (
        .clk50MHz(clk), .rst_n(rst_n), .rgb_in(rgb_a), .x_o(x_a), .y_o(y_a),
        .active_o(act_a), .pix_tick_o(tick_a), .frame_start_o(fs_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_blank_n(bl_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a));

    // dut_b: tiny 16x13 raster, active-high syncs, PIX_DIV=2, pattern colour
    logic [9:0] x_b, y_b; logic act_b, tick_b, fs_b, hs_b, vs_b, bl_b;
    logic [7:0] r_b, g_b, b_b; logic [23:0] rgb_b;
    assign rgb_b = {x_b[7:0], y_b[7:0], 8'hA5};
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(2)
    ) u_dut_b (
        .clk50MHz(clk), .rst_n(rst_n), .rgb_in(rgb_b), .x_o(x_b), .y_o(y_b),
        .active_o(act_b), .pix_tick_o(tick_b), .frame_start_o(fs_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank_n(bl_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b));

    // dut_c: default raster, PIX_DIV=1, constant white
    logic [9:0] x_c, y_c; logic act_c, tick_c, fs_c, hs_c, vs_c, bl_c;
    logic [7:0] r_c, g_c, b_c; logic [23:0] rgb_c;
    assign rgb_c = 24'hFFFFFF;
    vga_timing_gen #(.PIX_DIV(1)) u_dut_c (
        .clk50MHz(clk), .rst_n(rst_n), .rgb_in(rgb_c), .x_o(x_c), .y_o(y_c),
        .active_o(act_c), .pix_tick_o(tick_c), .frame_start_o(fs_c),
        .vga_hs(hs_c), .vga_vs(vs_c), .vga_blank_n(bl_c),
        .vga_r(r_c), .vga_g(g_c), .vga_b(b_c));

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string nm, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (n=%0d, t=%0t)", nm, got, exp, n, $time);
        end
    endtask

    // Expected outputs after n edges: pixel index p = ticks consumed; pins show pixel p-1.
    function automatic obs_t model(input int ne, input int pd,
                                   input int ha, input int hf, input int hsy, input int hb,
                                   input int va, input int vf, input int vsy, input int vb,
                                   input logic hp, input logic vp, input bit white);
        obs_t e;
        int ht, vt, tot, p, q, hq, vq;
        ht  = ha + hf + hsy + hb;
        vt  = va + vf + vsy + vb;
        tot = ht * vt;
        p   = (ne >= 2) ? (ne - 1) / pd : 0;
        e.x    = 10'(p % ht);
        e.y    = 10'((p / ht) % vt);
        e.act  = ((p % ht) < ha) && (((p / ht) % vt) < va);
        e.tick = (ne >= 1) && (ne % pd == 0);
        e.fs   = (ne >= 2) && ((ne - 1) % pd == 0) && (p % tot == 0);
        if (p == 0) begin
            e.hs = ~hp; e.vs = ~vp; e.blank = 1'b0; e.rgb = 24'h0;
        end else begin
            q  = p - 1;
            hq = q % ht;
            vq = (q / ht) % vt;
            e.hs    = (hq >= ha + hf && hq < ha + hf + hsy) ? hp : ~hp;
            e.vs    = (vq >= va + vf && vq < va + vf + vsy) ? vp : ~vp;
            e.blank = (hq < ha) && (vq < va);
            if (!e.blank)  e.rgb = 24'h0;
            else if (white) e.rgb = 24'hFFFFFF;
            else           e.rgb = {8'(hq), 8'(vq), 8'hA5};
        end
        return e;
    endfunction

    task automatic cmp_obs(input string tag, input obs_t g, input obs_t e);
        cmp({tag, "_x"},     int'(g.x),     int'(e.x));
        cmp({tag, "_y"},     int'(g.y),     int'(e.y));
        cmp({tag, "_active"},int'(g.act),   int'(e.act));
        cmp({tag, "_tick"},  int'(g.tick),  int'(e.tick));
        cmp({tag, "_fstart"},int'(g.fs),    int'(e.fs));
        cmp({tag, "_hs"},    int'(g.hs),    int'(e.hs));
        cmp({tag, "_vs"},    int'(g.vs),    int'(e.vs));
        cmp({tag, "_blank"}, int'(g.blank), int'(e.blank));
        cmp({tag, "_rgb"},   int'(g.rgb),   int'(e.rgb));
    endtask

    // Measurement state for the timing literals.
    logic p_hs_a, p_hs_c, p_bl_c, p_vs_b;
    int   fall_a, fall_c, rise_bl_c, rise_vs_b, last_fs_b;
    bit   ok_a, ok_c, ok_bl_c, ok_vs_b, ok_fs_b;
    int   falls_a, frames_b;

    task automatic monitor();
        if (!rst_n) begin
            ok_a = 0; ok_c = 0; ok_bl_c = 0; ok_vs_b = 0; ok_fs_b = 0;
            falls_a = 0; frames_b = 0;
        end else begin
            if (p_hs_a && !hs_a) begin
                cmp("a_hs_fall_x", int'(x_a), 657);
                if (ok_a) cmp("a_hs_period", n - fall_a, 1600);
                fall_a = n; ok_a = 1; falls_a = falls_a + 1;
            end
            if (!p_hs_a && hs_a && ok_a) cmp("a_hs_low", n - fall_a, 192);
            if (p_hs_c && !hs_c) begin
                cmp("c_hs_fall_x", int'(x_c), 657);
                if (ok_c) cmp("c_hs_period", n - fall_c, 800);
                fall_c = n; ok_c = 1;
            end
            if (!p_hs_c && hs_c && ok_c) cmp("c_hs_low", n - fall_c, 96);
            if (!p_bl_c && bl_c) begin rise_bl_c = n; ok_bl_c = 1; end
            if (p_bl_c && !bl_c && ok_bl_c) cmp("c_visible_run", n - rise_bl_c, 640);
            if (!p_vs_b && vs_b) begin rise_vs_b = n; ok_vs_b = 1; end
            if (p_vs_b && !vs_b && ok_vs_b) cmp("b_vs_width", n - rise_vs_b, 64);
            if (fs_b) begin
                if (ok_fs_b) cmp("b_frame_period", n - last_fs_b, 416);
                last_fs_b = n; ok_fs_b = 1; frames_b = frames_b + 1;
            end
        end
        p_hs_a = hs_a; p_hs_c = hs_c; p_bl_c = bl_c; p_vs_b = vs_b;
    endtask

    task automatic compare_all();
        obs_t g;
        g = '{x_a, y_a, act_a, tick_a, fs_a, hs_a, vs_a, bl_a, {r_a, g_a, b_a}};
        cmp_obs("a", g, model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1'b0));
        g = '{x_b, y_b, act_b, tick_b, fs_b, hs_b, vs_b, bl_b, {r_b, g_b, b_b}};
        cmp_obs("b", g, model(n, 2, 8, 2, 3, 3, 6, 2, 2, 3, 1'b1, 1'b1, 1'b0));
        g = '{x_c, y_c, act_c, tick_c, fs_c, hs_c, vs_c, bl_c, {r_c, g_c, b_c}};
        cmp_obs("c", g, model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1'b1));
        monitor();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            compare_all();
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        p_hs_a = 1'b1; p_hs_c = 1'b1; p_bl_c = 1'b0; p_vs_b = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(1200);

        // Asynchronous reset mid-line: pins return to reset values without a clock edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("rst_a_x", int'(x_a), 0);
        cmp("rst_a_y", int'(y_a), 0);
        cmp("rst_a_tick", int'(tick_a), 0);
        cmp("rst_a_hs", int'(hs_a), 1);
        cmp("rst_a_vs", int'(vs_a), 1);
        cmp("rst_a_blank", int'(bl_a), 0);
        cmp("rst_a_rgb", int'({r_a, g_a, b_a}), 0);
        cmp("rst_b_hs", int'(hs_b), 0);
        cmp("rst_c_tick", int'(tick_c), 0);
        run(4);

        // After release the first pixel tick of a PIX_DIV=2 build comes two clocks later.
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            cnt = cnt + 1;
            if (cnt == 1) cmp("rel_a_x0", int'(x_a), 0);
            if (tick_a) break;
        end
        cmp("first_tick_delay", cnt, 2);

        run(5200);
        cmp("a_hs_fall_count", falls_a, 3);
        cmp("b_frame_count", frames_b, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
